// File: rtl/multi_alarm_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multi_alarm_controller                                          |
// | N-channel countdown alarm, one SET/RUN/PAUSE/BEEP FSM per channel, shared  |
// | prescaled tick. Optional feature macro: AUTO_RELOAD_EN.                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module multi_alarm_controller #(
  parameter int WIDTH      = 9,
  parameter int CHANNELS   = 2,
  parameter int TICK_DIV   = 1000,
  parameter int BEEP_TICKS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS*WIDTH-1:0]   i_timer_in,
  input  logic [CHANNELS-1:0]         i_button,
  input  logic [CHANNELS-1:0]         i_clear,
  output logic [CHANNELS*WIDTH-1:0]   o_count,
  output logic [CHANNELS*2-1:0]       o_state,
  output logic [CHANNELS-1:0]         o_beep,
  output logic                        o_any_beep
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BEEP_TICKS > 0) ? $clog2(BEEP_TICKS + 1) : 1;
  localparam logic [PW-1:0] c_tick_last = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] c_beep_last = BW'(BEEP_TICKS);

  typedef enum logic [1:0] {
    ST_SET   = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_BEEP  = 2'b11
  } state_t;

  logic [PW-1:0]       r_presc;
  logic                w_tick;
  logic [CHANNELS-1:0] w_beep_nxt;
  logic                r_any_beep;

  assign w_tick = (r_presc == c_tick_last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_presc    <= '0;
      r_any_beep <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      r_any_beep <= |w_beep_nxt;
    end
  end

  assign o_any_beep = r_any_beep;

  genvar ch;
  generate
    for (ch = 0; ch < CHANNELS; ch++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_count;
      logic [WIDTH-1:0] w_count_nxt;
      logic [WIDTH-1:0] w_preset;
      logic [BW-1:0]    r_bcnt;
      logic [BW-1:0]    w_bcnt_nxt;
      logic [1:0]       r_btn_sr;
      logic [1:0]       r_clr_sr;
      logic             w_btn_ev;
      logic             w_clr_ev;
      logic             w_beep_pulse;
      logic             r_beep;
`ifdef AUTO_RELOAD_EN
      logic [WIDTH-1:0] r_reload;
      logic [WIDTH-1:0] w_reload_nxt;
`endif

      assign w_preset = i_timer_in[ch*WIDTH +: WIDTH];
      // Events fire on release (1 -> 0) of the synchronised level
      assign w_btn_ev = (r_btn_sr == 2'b10);
      assign w_clr_ev = (r_clr_sr == 2'b10);

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_state  <= ST_SET;
          r_count  <= '0;
          r_bcnt   <= '0;
          r_btn_sr <= 2'b00;
          r_clr_sr <= 2'b00;
          r_beep   <= 1'b0;
`ifdef AUTO_RELOAD_EN
          r_reload <= '0;
`endif
        end else begin
          r_btn_sr <= {r_btn_sr[0], i_button[ch]};
          r_clr_sr <= {r_clr_sr[0], i_clear[ch]};
          r_state  <= w_state_nxt;
          r_count  <= w_count_nxt;
          r_bcnt   <= w_bcnt_nxt;
          r_beep   <= w_beep_nxt[ch];
`ifdef AUTO_RELOAD_EN
          r_reload <= w_reload_nxt;
`endif
        end
      end

      always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_bcnt_nxt   = r_bcnt;
        w_beep_pulse = 1'b0;
`ifdef AUTO_RELOAD_EN
        w_reload_nxt = r_reload;
`endif
        case (r_state)
          ST_SET: begin
            w_count_nxt = w_preset;
            if (w_btn_ev) begin
              w_state_nxt = ST_RUN;
`ifdef AUTO_RELOAD_EN
              w_reload_nxt = w_preset;
`endif
            end
          end
          ST_RUN: begin
            if (w_clr_ev) begin
              w_state_nxt = ST_SET;
            end else if (w_btn_ev) begin
              w_state_nxt = ST_PAUSE;
            end else if (r_count == '0) begin
`ifdef AUTO_RELOAD_EN
              // A zero reload value would spin at zero, so it falls through to BEEP
              if (r_reload == '0) begin
                w_state_nxt = ST_BEEP;
                w_bcnt_nxt  = '0;
              end else begin
                w_count_nxt  = r_reload;
                w_beep_pulse = 1'b1;
              end
`else
              w_state_nxt = ST_BEEP;
              w_bcnt_nxt  = '0;
`endif
            end else if (w_tick) begin
              w_count_nxt = r_count - 1'b1;
            end
          end
          ST_PAUSE: begin
            if (w_clr_ev) begin
              w_state_nxt = ST_SET;
            end else if (w_btn_ev) begin
              w_state_nxt = ST_RUN;
            end
          end
          ST_BEEP: begin
            w_count_nxt = '0;
            if (w_clr_ev) begin
              w_state_nxt = ST_SET;
            end else if ((BEEP_TICKS != 0) && w_tick) begin
              w_bcnt_nxt = r_bcnt + 1'b1;
              if (w_bcnt_nxt == c_beep_last) begin
                w_state_nxt = ST_SET;
              end
            end
          end
          default: w_state_nxt = ST_SET;
        endcase
      end

      assign w_beep_nxt[ch]                  = (w_state_nxt == ST_BEEP) || w_beep_pulse;
      assign o_count[ch*WIDTH +: WIDTH]      = r_count;
      assign o_state[ch*2 +: 2]              = r_state;
      assign o_beep[ch]                      = r_beep;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_multi_alarm_controller                                       |
// | Randomised bench for multi_alarm_controller with a reference-model         |
// | scoreboard. Revision : 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_multi_alarm_controller;

  localparam int WIDTH      = 9;
  localparam int CHANNELS   = 2;
  localparam int TICK_DIV   = 4;
  localparam int BEEP_TICKS = 3;
  localparam int OUTW       = CHANNELS*WIDTH + CHANNELS*2 + CHANNELS + 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [CHANNELS*WIDTH-1:0] timer_in;
  logic [CHANNELS-1:0]       button;
  logic [CHANNELS-1:0]       clear;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS*2-1:0]     state;
  logic [CHANNELS-1:0]       beep;
  logic                      any_beep;

  always #5 clk = ~clk;

  multi_alarm_controller #(
    .WIDTH      (WIDTH),
    .CHANNELS   (CHANNELS),
    .TICK_DIV   (TICK_DIV),
    .BEEP_TICKS (BEEP_TICKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_timer_in (timer_in),
    .i_button   (button),
    .i_clear    (clear),
    .o_count    (count),
    .o_state    (state),
    .o_beep     (beep),
    .o_any_beep (any_beep)
  );

  // Reference model: mode 0 SET, 1 RUN, 2 PAUSE, 3 BEEP
  int  m_mode   [CHANNELS];
  int  m_cnt    [CHANNELS];
  int  m_left   [CHANNELS];
  int  m_reload [CHANNELS];
  bit  m_pulse  [CHANNELS];
  bit  m_b_old  [CHANNELS];
  bit  m_b_new  [CHANNELS];
  bit  m_c_old  [CHANNELS];
  bit  m_c_new  [CHANNELS];
  int  m_since;
  bit  m_valid = 1'b0;

  logic [OUTW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin : model
    logic [CHANNELS*WIDTH-1:0] ec;
    logic [CHANNELS*2-1:0]     es;
    logic [CHANNELS-1:0]       eb;
    bit tick, bev, cev;
    int pre;
    if (reset === 1'b0) begin
      m_valid = 1'b1;
      m_since = 0;
      for (int c = 0; c < CHANNELS; c++) begin
        m_mode[c] = 0; m_cnt[c] = 0; m_left[c] = 0; m_reload[c] = 0; m_pulse[c] = 1'b0;
        m_b_old[c] = 1'b0; m_b_new[c] = 1'b0; m_c_old[c] = 1'b0; m_c_new[c] = 1'b0;
      end
    end else if (m_valid) begin
      m_since = m_since + 1;
      tick = ((m_since % TICK_DIV) == 0);
      for (int c = 0; c < CHANNELS; c++) begin
        bev = m_b_old[c] && !m_b_new[c];
        cev = m_c_old[c] && !m_c_new[c];
        m_b_old[c] = m_b_new[c]; m_b_new[c] = button[c];
        m_c_old[c] = m_c_new[c]; m_c_new[c] = clear[c];
        pre = int'(timer_in[c*WIDTH +: WIDTH]);
        m_pulse[c] = 1'b0;
        case (m_mode[c])
          0: begin
            m_cnt[c] = pre;
            if (bev) begin m_mode[c] = 1; m_reload[c] = pre; end
          end
          1: begin
            if (cev) m_mode[c] = 0;
            else if (bev) m_mode[c] = 2;
            else if (m_cnt[c] == 0) begin
`ifdef AUTO_RELOAD_EN
              if (m_reload[c] == 0) begin m_mode[c] = 3; m_left[c] = BEEP_TICKS; end
              else begin m_cnt[c] = m_reload[c]; m_pulse[c] = 1'b1; end
`else
              m_mode[c] = 3; m_left[c] = BEEP_TICKS;
`endif
            end else if (tick) m_cnt[c] = m_cnt[c] - 1;
          end
          2: begin
            if (cev) m_mode[c] = 0;
            else if (bev) m_mode[c] = 1;
          end
          default: begin
            m_cnt[c] = 0;
            if (cev) m_mode[c] = 0;
            else if (BEEP_TICKS != 0 && tick) begin
              m_left[c] = m_left[c] - 1;
              if (m_left[c] == 0) m_mode[c] = 0;
            end
          end
        endcase
      end
    end
    if (m_valid) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ec[c*WIDTH +: WIDTH] = WIDTH'(m_cnt[c]);
        es[c*2 +: 2]         = 2'(m_mode[c]);
        eb[c]                = (m_mode[c] == 3) || m_pulse[c];
      end
      exp_q.push_back({|eb, eb, es, ec});
    end
  end

  always @(negedge clk) begin : monitor
    logic [OUTW-1:0] e;
    logic [OUTW-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {any_beep, beep, state, count};
      checks = checks + 1;
      if (a !== e) begin
        errors = errors + 1;
        $display("FAIL outputs t=%0t act any=%b beep=%b state=%b count=%h req any=%b beep=%b state=%b count=%h",
                 $time, a[OUTW-1], a[OUTW-2 -: CHANNELS], a[CHANNELS*WIDTH +: CHANNELS*2],
                 a[CHANNELS*WIDTH-1:0], e[OUTW-1], e[OUTW-2 -: CHANNELS],
                 e[CHANNELS*WIDTH +: CHANNELS*2], e[CHANNELS*WIDTH-1:0]);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_timer(input int c, input int v);
    timer_in[c*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  // Press the selected buttons for two cycles, then release them together
  task automatic release_in(input logic [CHANNELS-1:0] b, input logic [CHANNELS-1:0] c);
    button = button | b;
    clear  = clear | c;
    cycles(2);
    button = button & ~b;
    clear  = clear & ~c;
    cycles(1);
  endtask

  initial begin
    reset    = 1'b0;
    button   = CHANNELS'($urandom);
    clear    = CHANNELS'($urandom);
    timer_in = {CHANNELS{WIDTH'($urandom)}};
    @(negedge clk);
    reset  = 1'b1;
    button = '0;
    clear  = '0;
    set_timer(0, 5);
    set_timer(1, 7);
    cycles(3);

    release_in(2'b01, 2'b00);
    cycles(45);

    set_timer(0, 6);
    release_in(2'b01, 2'b00);
    cycles(12);
    release_in(2'b01, 2'b00);
    cycles(20);
    release_in(2'b01, 2'b00);
    cycles(40);

    set_timer(1, 9);
    release_in(2'b10, 2'b00);
    cycles(6);
    release_in(2'b10, 2'b10);
    cycles(5);

    set_timer(0, 0);
    release_in(2'b01, 2'b00);
    cycles(20);

    set_timer(0, 1);
    release_in(2'b01, 2'b00);
    cycles(10);
    release_in(2'b00, 2'b01);
    cycles(4);
    set_timer(0, 8);
    release_in(2'b01, 2'b00);
    cycles(5);
    release_in(2'b01, 2'b00);
    cycles(3);
    release_in(2'b00, 2'b01);
    cycles(4);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) != 0);
      for (int c = 0; c < CHANNELS; c++) begin
        if ($urandom_range(0, 5) == 0)   button[c] = ~button[c];
        if ($urandom_range(0, 19) == 0)  clear[c]  = ~clear[c];
        if ($urandom_range(0, 24) == 0)  set_timer(c, int'($urandom_range(0, 12)));
      end
    end
    reset  = 1'b1;
    button = '0;
    clear  = '0;
    cycles(3);

    if (checks < 100) begin
      errors = errors + 1;
      $display("FAIL check_count act=%0d req>=100", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
